// File: rtl/quiz_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quiz_arbiter_if: host/key inputs and display/buzzer outputs           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface quiz_arbiter_if #(
    parameter int NUM_PLAYERS = 4
);
    logic                   Start;
    logic                   Clear;
    logic [NUM_PLAYERS-1:0] Keys;
    logic [3:0]             Player_Number;
    logic                   Foul;
    logic [3:0]             TimerH;
    logic [3:0]             TimerL;
    logic                   Buzzer_Answer;
    logic                   Buzzer_TimeOver;
    logic [1:0]             State;

    modport master (
        output Start, Clear, Keys,
        input  Player_Number, Foul, TimerH, TimerL,
               Buzzer_Answer, Buzzer_TimeOver, State
    );

    modport slave (
        input  Start, Clear, Keys,
        output Player_Number, Foul, TimerH, TimerL,
               Buzzer_Answer, Buzzer_TimeOver, State
    );
endinterface
`default_nettype wire

// File: rtl/quiz_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quiz_arbiter: N-player buzz-in arbiter with BCD countdown and buzzers |
// | Optional macro FOUL_DETECT_EN enables false-start detection in IDLE.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module quiz_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int TICK_DIV    = 50000000,
    parameter int ANSWER_SECS = 30,
    parameter int BUZZ_CYCLES = 25000000
) (
    input  wire logic     CLK,
    input  wire logic     RSTn,
    quiz_arbiter_if.slave bus
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam int                BUZZ_W    = $clog2(BUZZ_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES - 1);
    localparam logic [3:0]        RELOAD_H  = 4'(ANSWER_SECS / 10);
    localparam logic [3:0]        RELOAD_L  = 4'(ANSWER_SECS % 10);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        ANSWER = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [NUM_PLAYERS-1:0] keys_i;
    logic [NUM_PLAYERS-1:0] keys_q;
    logic [NUM_PLAYERS-1:0] press;
    logic                   press_any;
    logic [3:0]             winner;
    logic [3:0]             player_q;
    logic [3:0]             timer_h_q;
    logic [3:0]             timer_l_q;
    logic [3:0]             timer_h_d;
    logic [3:0]             timer_l_d;
    logic [TICK_W-1:0]      tick_q;
    logic                   tick;
    logic                   timeout;
    logic                   buzz_a_q;
    logic                   buzz_t_q;
    logic [BUZZ_W-1:0]      buzz_a_cnt_q;
    logic [BUZZ_W-1:0]      buzz_t_cnt_q;
`ifdef FOUL_DETECT_EN
    logic                   foul_q;
`endif

    assign keys_i    = bus.Keys;
    assign press     = keys_q & ~keys_i;
    assign press_any = |press;

    // Scan from the top so the lowest simultaneous index is the last writer.
    always_comb begin
        winner = 4'd0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (press[i]) winner = 4'(i + 1);
        end
    end

    always_comb begin
        timer_h_d = timer_h_q;
        timer_l_d = timer_l_q - 4'd1;
        if (timer_l_q == 4'd0) begin
            timer_h_d = timer_h_q - 4'd1;
            timer_l_d = 4'd9;
        end
    end

    assign tick    = (tick_q == TICK_LAST);
    assign timeout = tick && (timer_h_d == 4'd0) && (timer_l_d == 4'd0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            keys_q       <= '1;
            player_q     <= 4'd0;
            timer_h_q    <= RELOAD_H;
            timer_l_q    <= RELOAD_L;
            tick_q       <= '0;
            buzz_a_q     <= 1'b0;
            buzz_t_q     <= 1'b0;
            buzz_a_cnt_q <= '0;
            buzz_t_cnt_q <= '0;
`ifdef FOUL_DETECT_EN
            foul_q       <= 1'b0;
`endif
        end else begin
            keys_q <= keys_i;

            // Buzzer countdowns; any trigger below overrides and restarts them.
            if (buzz_a_q) begin
                if (buzz_a_cnt_q == '0) buzz_a_q <= 1'b0;
                else                    buzz_a_cnt_q <= buzz_a_cnt_q - 1'b1;
            end
            if (buzz_t_q) begin
                if (buzz_t_cnt_q == '0) buzz_t_q <= 1'b0;
                else                    buzz_t_cnt_q <= buzz_t_cnt_q - 1'b1;
            end

            if (bus.Clear) begin
                state_q   <= IDLE;
                player_q  <= 4'd0;
                timer_h_q <= RELOAD_H;
                timer_l_q <= RELOAD_L;
                tick_q    <= '0;
                buzz_a_q  <= 1'b0;
                buzz_t_q  <= 1'b0;
`ifdef FOUL_DETECT_EN
                foul_q    <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        tick_q <= '0;
`ifdef FOUL_DETECT_EN
                        if (press_any) begin
                            state_q      <= DONE;
                            player_q     <= winner;
                            foul_q       <= 1'b1;
                            buzz_t_q     <= 1'b1;
                            buzz_t_cnt_q <= BUZZ_LOAD;
                        end else
`endif
                        if (bus.Start) state_q <= OPEN;
                    end
                    OPEN, ANSWER: begin
                        if (state_q == OPEN && press_any) begin
                            state_q      <= ANSWER;
                            player_q     <= winner;
                            timer_h_q    <= RELOAD_H;
                            timer_l_q    <= RELOAD_L;
                            tick_q       <= '0;
                            buzz_a_q     <= 1'b1;
                            buzz_a_cnt_q <= BUZZ_LOAD;
                        end else if (tick) begin
                            tick_q    <= '0;
                            timer_h_q <= timer_h_d;
                            timer_l_q <= timer_l_d;
                            if (timeout) begin
                                state_q      <= DONE;
                                buzz_t_q     <= 1'b1;
                                buzz_t_cnt_q <= BUZZ_LOAD;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.State           = state_q;
    assign bus.Player_Number   = player_q;
    assign bus.TimerH          = timer_h_q;
    assign bus.TimerL          = timer_l_q;
    assign bus.Buzzer_Answer   = buzz_a_q;
    assign bus.Buzzer_TimeOver = buzz_t_q;
`ifdef FOUL_DETECT_EN
    assign bus.Foul            = foul_q;
`else
    assign bus.Foul            = 1'b0;
`endif

endmodule
`default_nettype wire
